// File: rtl/controle_multiciclo_if.sv
// Bundle between the multicycle controller and its datapath/memory:
// decode inputs, memory handshake and the per-cycle control lines.
interface controle_multiciclo_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_addr_sel;
  logic       pc_source;
  logic       illegal;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] mem_to_reg;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, mem_addr_sel,
           pc_source, illegal, alu_src_a, alu_src_b, alu_op, mem_to_reg
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_addr_sel,
           pc_source, illegal, alu_src_a, alu_src_b, alu_op, mem_to_reg
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V style control unit: sequences fetch/decode/execute,
// waits on memory handshakes and counts retired instructions.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | dispatch on opcode, precompute branch target
// MEM_ADDR  | rs1 + imm effective address
// MEM_READ  | load access, held until mem_ready
// MEM_WB    | write MDR into rd
// MEM_WRITE | store access, held until mem_ready
// EXEC_R    | register-register ALU op
// EXEC_I    | register-immediate ALU op
// ALU_WB    | write ALUOut into rd
// BRANCH    | compare, conditionally load target
// JAL       | link and jump
// HALT      | unknown opcode/funct3, parked until reset
module controle_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  controle_multiciclo_if.master bus,
  output logic [3:0]           estado,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    HALT      = 4'd11
  } state_t;

  state_t state, nxt;

  always_comb begin
    nxt = state;
    case (state)
      FETCH:     if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          7'b0110011:             nxt = EXEC_R;
          7'b0010011:             nxt = EXEC_I;
          7'b0000011, 7'b0100011: nxt = MEM_ADDR;
          7'b1100011:             nxt = BRANCH;
          7'b1101111:             nxt = JAL;
          default:                nxt = HALT;
        endcase
      end
      MEM_ADDR:  nxt = (bus.opcode == 7'b0000011) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) nxt = MEM_WB;
      MEM_WB:    nxt = FETCH;
      MEM_WRITE: if (bus.mem_ready) nxt = FETCH;
      EXEC_R:    nxt = ALU_WB;
      EXEC_I:    nxt = ALU_WB;
      ALU_WB:    nxt = FETCH;
      BRANCH:    nxt = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) ? FETCH : HALT;
      JAL:       nxt = FETCH;
      HALT:      nxt = HALT;
      default:   nxt = HALT;
    endcase
  end

  // A retire is any entry into FETCH; FETCH waiting on itself is not one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (nxt == FETCH && state != FETCH)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.pc_source    = 1'b0;
    bus.illegal      = 1'b0;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.alu_op       = 2'b00;
    bus.mem_to_reg   = 2'b00;
    case (state)
      FETCH: begin
        // mem_ready must not latch IR/PC while reset is held
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready & reset;
        bus.pc_write  = bus.mem_ready & reset;
      end
      DECODE: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        bus.mem_read     = 1'b1;
        bus.mem_addr_sel = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      MEM_WRITE: begin
        bus.mem_write    = 1'b1;
        bus.mem_addr_sel = 1'b1;
      end
      EXEC_R: begin
        bus.alu_src_a = 2'b01;
        bus.alu_op    = 2'b10;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
      end
      ALU_WB: bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 2'b01;
        bus.alu_op    = 2'b01;
        bus.pc_source = 1'b1;
        if (bus.funct3 == 3'b000)      bus.pc_write = bus.zero;
        else if (bus.funct3 == 3'b001) bus.pc_write = ~bus.zero;
      end
      JAL: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b10;
        bus.pc_write   = 1'b1;
        bus.pc_source  = 1'b1;
      end
      HALT:    bus.illegal = 1'b1;
      default: bus.illegal = 1'b1;
    endcase
  end

  assign estado = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Random instruction stream against a phase-level model of the controller,
// plus directed halt, bad-branch and reset-during-store scenarios.
module tb_controle_multiciclo;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  controle_multiciclo_if ifc ();
  controle_multiciclo_if ifc4 ();

  assign ifc4.opcode    = ifc.opcode;
  assign ifc4.funct3    = ifc.funct3;
  assign ifc4.zero      = ifc.zero;
  assign ifc4.mem_ready = ifc.mem_ready;

  logic [3:0]  estado, estado4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  controle_multiciclo #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .bus(ifc.master),
    .estado(estado), .instr_count(cnt)
  );

  controle_multiciclo #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .bus(ifc4.master),
    .estado(estado4), .instr_count(cnt4)
  );

  localparam logic [7:0] PCW = 8'h80, IRW = 8'h40, RW = 8'h20, MRD = 8'h10,
                         MWR = 8'h08, MAS = 8'h04, PCS = 8'h02, ILL = 8'h01;

  logic [15:0] obs;
  assign obs = {ifc.pc_write, ifc.ir_write, ifc.reg_write, ifc.mem_read,
                ifc.mem_write, ifc.mem_addr_sel, ifc.pc_source, ifc.illegal,
                ifc.alu_src_a, ifc.alu_src_b, ifc.alu_op, ifc.mem_to_reg};

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  function automatic logic [15:0] mk(input logic [7:0] f, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] mtr);
    return {f, a, b, op, mtr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, sample just after.
  task automatic cyc(input logic mr, input logic z, input logic [6:0] op,
                     input logic [2:0] f3, input logic [3:0] st, input logic [15:0] ctl);
    @(negedge clock);
    ifc.mem_ready = mr;
    ifc.zero      = z;
    ifc.opcode    = op;
    ifc.funct3    = f3;
    #1;
    chk("estado", 32'(estado), 32'(st));
    chk("estado_w4", 32'(estado4), 32'(st));
    chk("ctl", 32'(obs), 32'(ctl));
  endtask

  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
    int w;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++)
      cyc(1'b0, 1'($urandom), op, f3, 4'd0, mk(MRD, 2'b00, 2'b01, 2'b00, 2'b00));
    cyc(1'b1, 1'($urandom), op, f3, 4'd0, mk(PCW | IRW | MRD, 2'b00, 2'b01, 2'b00, 2'b00));
    chk("instr_count", cnt, 32'(exp_count));
    chk("instr_count_w4", 32'(cnt4), 32'(exp_count & 15));
    cyc(1'($urandom), 1'($urandom), op, f3, 4'd1, mk(8'h00, 2'b10, 2'b10, 2'b00, 2'b00));
  endtask

  task automatic mem_wait(input logic [6:0] op, input logic [2:0] f3,
                          input logic [3:0] st, input logic [15:0] ctl);
    int w;
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) cyc(1'b0, 1'($urandom), op, f3, st, ctl);
    cyc(1'b1, 1'($urandom), op, f3, st, ctl);
  endtask

  task automatic run_instr(input int kind);
    logic [6:0] op;
    logic [2:0] f3;
    logic z;
    f3 = 3'($urandom);
    z  = 1'($urandom);
    case (kind)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: begin op = 7'b1100011; f3 = 3'b000; end
      5: begin op = 7'b1100011; f3 = 3'b001; end
      default: op = 7'b1101111;
    endcase
    fetch_decode(op, f3);
    case (kind)
      0: begin
        cyc(1'($urandom), z, op, f3, 4'd6, mk(8'h00, 2'b01, 2'b00, 2'b10, 2'b00));
        cyc(1'($urandom), z, op, f3, 4'd8, mk(RW, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      1: begin
        cyc(1'($urandom), z, op, f3, 4'd7, mk(8'h00, 2'b01, 2'b10, 2'b11, 2'b00));
        cyc(1'($urandom), z, op, f3, 4'd8, mk(RW, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      2: begin
        cyc(1'($urandom), z, op, f3, 4'd2, mk(8'h00, 2'b01, 2'b10, 2'b00, 2'b00));
        mem_wait(op, f3, 4'd3, mk(MRD | MAS, 2'b00, 2'b00, 2'b00, 2'b00));
        cyc(1'($urandom), z, op, f3, 4'd4, mk(RW, 2'b00, 2'b00, 2'b00, 2'b01));
      end
      3: begin
        cyc(1'($urandom), z, op, f3, 4'd2, mk(8'h00, 2'b01, 2'b10, 2'b00, 2'b00));
        mem_wait(op, f3, 4'd5, mk(MWR | MAS, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      4: cyc(1'($urandom), z, op, f3, 4'd9,
             mk((z ? PCW : 8'h00) | PCS, 2'b01, 2'b00, 2'b01, 2'b00));
      5: cyc(1'($urandom), z, op, f3, 4'd9,
             mk((z ? 8'h00 : PCW) | PCS, 2'b01, 2'b00, 2'b01, 2'b00));
      default: cyc(1'($urandom), z, op, f3, 4'd10, mk(RW | PCW | PCS, 2'b00, 2'b00, 2'b00, 2'b10));
    endcase
    exp_count++;
  endtask

  // Assert reset mid-cycle, check the immediate FETCH decode, release after one edge.
  task automatic reset_check();
    ifc.mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_ctl", 32'(obs), 32'(mk(MRD, 2'b00, 2'b01, 2'b00, 2'b00)));
    chk("rst_count", cnt, 32'd0);
    chk("rst_count_w4", 32'(cnt4), 32'd0);
    exp_count = 0;
    @(negedge clock);
    #1;
    ifc.mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    ifc.opcode = 7'd0;
    ifc.funct3 = 3'd0;
    ifc.zero = 1'b0;
    ifc.mem_ready = 1'b0;
    reset_check();

    for (int n = 0; n < 150; n++) run_instr(int'($urandom_range(0, 6)));

    // unknown opcode parks in HALT
    fetch_decode(7'b1111111, 3'd0);
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom), 1'($urandom), 7'b1111111, 3'd0, 4'd11, mk(ILL, 2'b00, 2'b00, 2'b00, 2'b00));
    #1;
    reset_check();

    // branch with unsupported funct3
    fetch_decode(7'b1100011, 3'b010);
    cyc(1'b1, 1'b1, 7'b1100011, 3'b010, 4'd9, mk(PCS, 2'b01, 2'b00, 2'b01, 2'b00));
    cyc(1'b1, 1'b0, 7'b1100011, 3'b010, 4'd11, mk(ILL, 2'b00, 2'b00, 2'b00, 2'b00));
    #1;
    reset_check();

    for (int n = 0; n < 5; n++) run_instr(int'($urandom_range(0, 6)));

    // store interrupted by reset while waiting on memory
    fetch_decode(7'b0100011, 3'b010);
    cyc(1'b0, 1'b0, 7'b0100011, 3'b010, 4'd2, mk(8'h00, 2'b01, 2'b10, 2'b00, 2'b00));
    cyc(1'b0, 1'b0, 7'b0100011, 3'b010, 4'd5, mk(MWR | MAS, 2'b00, 2'b00, 2'b00, 2'b00));
    #1;
    reset_check();

    for (int n = 0; n < 20; n++) run_instr(int'($urandom_range(0, 6)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
